kbd_io_ctrl: RTL



---
 rtl/io_map_pkg.sv | 21 ++
 rtl/kbd_io_ctrl_if.sv | 19 +
 rtl/kbd_fifo.sv | 58 +++++
 rtl/kbd_io_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared I/O address map for the CPU data port: I/O window select,
// register word offsets and KBD_STATUS bit positions.
package io_map_pkg;

    localparam logic [3:0] IO_BASE_DEFAULT = 4'hA;

    // Word offsets, compared against m_addr[3:2]
    localparam logic [1:0] KBD_DATA_OFS   = 2'd0;
    localparam logic [1:0] KBD_STATUS_OFS = 2'd1;
    localparam logic [1:0] LED_OFS        = 2'd2;
    localparam logic [1:0] KBD_CTRL_OFS   = 2'd3;

    localparam int STAT_NEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_COUNT_LSB  = 8;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/kbd_io_ctrl_if.sv
// CPU data-port bus as seen by memory-mapped I/O blocks.
interface kbd_io_ctrl_if;
    logic [31:0] m_addr;
    logic        m_read;
    logic        m_write;
    logic [31:0] d_t_mem;
    logic        io_sel;
    logic [31:0] io_rdata;

    modport master (
        output m_addr, m_read, m_write, d_t_mem,
        input  io_sel, io_rdata
    );

    modport slave (
        input  m_addr, m_read, m_write, d_t_mem,
        output io_sel, io_rdata
    );
endinterface

// File: rtl/kbd_fifo.sv
// Scan-code FIFO: combinational head, flush dominates push/pop, a pop on a
// full FIFO frees the slot for a same-cycle push.
module kbd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/kbd_io_ctrl.sv
// Memory-mapped keyboard/LED controller: address decode, scan-code FIFO,
// LED register and read mux. Define KBD_OVF_FLAG_EN for the sticky overflow flag.
module kbd_io_ctrl
    import io_map_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [3:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               clr,
    kbd_io_ctrl_if.slave       bus,
    input  logic [7:0]         kbd_data,
    input  logic               kbd_valid,
    output logic [15:0]        led
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  reg_ofs;
    logic        rd_en;
    logic        wr_en;
    logic        pop_req;
    logic        flush;
    logic        ovf;
    logic [7:0]  head;
    logic [AW:0] count;
    logic [7:0]  count8;
    logic        full;
    logic        empty;
    logic [31:0] status_word;
    logic [31:0] rdata_mux;
    logic        unused_bits;

    assign bus.io_sel = (bus.m_addr[31:28] == IO_BASE);
    assign reg_ofs    = bus.m_addr[3:2];
    assign rd_en      = bus.io_sel & bus.m_read & ~clr;
    assign wr_en      = bus.io_sel & bus.m_write;
    assign pop_req    = rd_en & (reg_ofs == KBD_DATA_OFS);
    assign flush      = wr_en & (reg_ofs == KBD_CTRL_OFS) & bus.d_t_mem[CTRL_FLUSH_BIT];
    assign count8     = 8'(count);

    assign unused_bits = ^{bus.m_addr[27:4], bus.m_addr[1:0], bus.d_t_mem[31:16],
                           bus.d_t_mem[CTRL_CLR_OVF_BIT]};

    kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (kbd_valid),
        .pop   (pop_req),
        .flush (flush),
        .wdata (kbd_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef KBD_OVF_FLAG_EN
    logic ovf_set;
    logic ovf_clr;

    // A pop in the same cycle makes room, so only a push with no slot overflows
    assign ovf_set = kbd_valid & full & ~(pop_req & ~empty) & ~flush;
    assign ovf_clr = wr_en & (reg_ofs == KBD_CTRL_OFS) & bus.d_t_mem[CTRL_CLR_OVF_BIT];

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            led <= '0;
        else if (wr_en && reg_ofs == LED_OFS)
            led <= bus.d_t_mem[15:0];
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_NEMPTY_BIT] = ~empty;
        status_word[STAT_FULL_BIT]   = full;
        status_word[STAT_OVF_BIT]    = ovf;
        status_word[STAT_COUNT_LSB +: 8] = count8;
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_ofs)
            KBD_DATA_OFS:   rdata_mux = {24'h0, (empty ? 8'h00 : head)};
            KBD_STATUS_OFS: rdata_mux = status_word;
            LED_OFS:        rdata_mux = {16'h0, led};
            default:        rdata_mux = '0;
        endcase
    end

    assign bus.io_rdata = rd_en ? rdata_mux : 32'h0;
endmodule
